multiplicador_seq: RTL and testbench
====================================

MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The block SHALL have port A, input, N bits: multiplicand.
REQ-006 The block SHALL have port B, input, N bits: multiplier.
REQ-007 The block SHALL have port P, output, 2N bits: registered product of the last completed operation.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the cycle in which a new P is first valid.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, CALC and DONE.
REQ-011 In IDLE or DONE, a rising edge with start=1 SHALL latch A and B into internal registers, clear the accumulator and iteration counter, and enter CALC.
REQ-012 In IDLE, a rising edge with start=0 SHALL keep the FSM in IDLE; in DONE, such an edge SHALL move the FSM to IDLE.
REQ-013 Each CALC cycle SHALL add the multiplicand, shifted left by the counter value, to the accumulator when the current multiplier bit is 1, then increment the counter; iterations run bit 0 to bit N-1.
REQ-014 CALC SHALL last exactly N cycles; on the Nth CALC edge, P SHALL load the full 2N-bit result and the FSM SHALL enter DONE.
REQ-015 Latency: for start sampled at edge k, P and done SHALL be valid after edge k+N; done SHALL be high only between edges k+N and k+N+1.
REQ-016 busy SHALL be 1 exactly while the FSM is in CALC.
REQ-017 start asserted during CALC SHALL be ignored; it SHALL NOT restart the operation or alter the latched operands.
REQ-018 Operand changes on A or B after the start edge SHALL NOT affect the result in progress.
REQ-019 P SHALL hold its value between completions and SHALL change only on the completing CALC edge.
REQ-020 Start accepted in DONE (back-to-back operation) SHALL give the same N-cycle latency; done SHALL then be low during the new CALC.
REQ-021 All arithmetic SHALL be exact to 2N bits, with no truncation or overflow; a zero operand SHALL still take N cycles and give P=0.

Reset
REQ-022 Reset SHALL, asynchronously and at any time including mid-CALC, force the FSM to IDLE and clear P, busy, done, the counter, the accumulator and the latched operands.
REQ-023 The first rising edge after rst deasserts SHALL be treated as an ordinary IDLE cycle, so that start=1 on that edge is accepted.

Configuration
REQ-024 When macro SIGNED_MODE_EN is defined, the block SHALL add input port sgn (1 bit), sampled together with A and B on the start edge.
REQ-025 With SIGNED_MODE_EN defined and sgn=1, A, B and P SHALL be two's complement: the block multiplies the operand magnitudes and negates the result when the operand signs differ, with unchanged latency.
REQ-026 With SIGNED_MODE_EN defined and sgn=0, and whenever SIGNED_MODE_EN is undefined, the block SHALL perform unsigned multiplication; when the macro is undefined, port sgn SHALL be absent.

Verification
REQ-027 N=4, A=15, B=15, one-cycle start pulse -> busy high for 4 cycles, then P=8'hE1 (225) with done high for exactly 1 cycle.
REQ-028 N=4, A=0, B=9 -> P=0 after 4 CALC cycles; the previous nonzero P is held until that completion edge.
REQ-029 N=4, A=3, B=5 started, then start=1 with A=7, B=7 during CALC -> P=15, and no restart.
REQ-030 Assert rst during the 2nd CALC cycle of 15x15 -> all outputs 0 immediately, and no done pulse; after release, 2x3 -> P=6.
REQ-031 Back-to-back: start held high through DONE with A=2, B=2, then A=4, B=4 -> P=4, then P=16, with done pulses exactly 5 cycles apart.
REQ-032 With SIGNED_MODE_EN defined and sgn=1, N=4: -3x5 -> P=8'hF1; -8x-8 -> P=8'h40; with sgn=0, 4'hD x 5 -> P=8'h41.

Source files
------------

// File: rtl/multiplicador_seq.sv
// Sequential shift-and-add multiplier: N CALC cycles per product, registered P/busy/done.
// Optional SIGNED_MODE_EN adds port sgn for two's complement operands (sign-magnitude core).
module multiplicador_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
`ifdef SIGNED_MODE_EN
  input  logic           sgn,
`endif
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  state;
  logic        [CW-1:0]    cnt;
  logic        [2*N-1:0]   acc;
  logic        [2*N-1:0]   mcand;
  logic        [N-1:0]     mplier;
  logic                    neg;
  logic                    sgn_w;
  logic        [2*N-1:0]   addend;
  logic        [2*N-1:0]   sum;

`ifdef SIGNED_MODE_EN
  assign sgn_w = sgn;
`else
  assign sgn_w = 1'b0;
`endif

  // Magnitude of an operand; the most negative value maps to 2^(N-1), which still fits.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic is_signed);
    return (is_signed && v[N-1]) ? -v : v;
  endfunction

  function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v, input logic negate);
    return negate ? -v : v;
  endfunction

  // mcand is pre-shifted each cycle, so it always equals the multiplicand << cnt.
  always_comb begin
    addend = '0;
    if (mplier[0]) addend = mcand;
    sum = acc + addend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      P      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{N{1'b0}}, mag(A, sgn_w)};
            mplier <= mag(B, sgn_w);
            neg    <= sgn_w & (A[N-1] ^ B[N-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_CALC;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_CALC: begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            P     <= apply_sign(sum, neg);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Directed self-checking bench for multiplicador_seq (N=4); signed vectors run when SIGNED_MODE_EN is set.
module tb_multiplicador_seq;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           sgn;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;

  multiplicador_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SIGNED_MODE_EN
    .sgn   (sgn),
`endif
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, wait (bounded) for done, check latency and product.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic [2*N-1:0] exp);
    int n;
    A = a; B = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, n, 4);
    check_eq({tag, "_P"}, P, exp);
  endtask

  initial begin
    int first_done, second_done, cyc;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; sgn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_P", P, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // 15 x 15: busy for four samples, then done pulse with 225
    A = 4'd15; B = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ff_busy%0d", i), busy, 1);
      check_eq($sformatf("ff_done%0d", i), done, 0);
      @(negedge clk);
    end
    check_eq("ff_P", P, 8'hE1);
    check_eq("ff_done", done, 1);
    check_eq("ff_busy_end", busy, 0);
    @(negedge clk);
    check_eq("ff_done_pulse", done, 0);
    check_eq("ff_P_hold", P, 8'hE1);

    // 0 x 9: previous P held until the completion edge
    A = 4'd0; B = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("z_hold%0d", i), P, 8'hE1);
      @(negedge clk);
    end
    check_eq("z_P", P, 0);
    check_eq("z_done", done, 1);
    @(negedge clk);

    // 3 x 5 with start re-asserted and operands changed during CALC
    A = 4'd3; B = 4'd5; start = 1'b1;
    @(negedge clk);
    A = 4'd7; B = 4'd7;
    repeat (3) @(negedge clk);
    check_eq("ign_done_early", done, 0);
    check_eq("ign_busy", busy, 1);
    @(negedge clk);
    check_eq("ign_done", done, 1);
    check_eq("ign_P", P, 8'd15);
    start = 1'b0;
    @(negedge clk);
    check_eq("ign_no_restart", busy, 0);
    check_eq("ign_done_low", done, 0);

    // Reset during the second CALC cycle of 15 x 15
    A = 4'd15; B = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_P", P, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("mid_rst_nodone%0d", i), done, 0);
    end
    // Release with start already high: first edge must accept it
    rst = 1'b0; A = 4'd2; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("post_rst_busy", busy, 1);
    repeat (4) @(negedge clk);
    check_eq("post_rst_P", P, 8'd6);
    check_eq("post_rst_done", done, 1);
    @(negedge clk);

    // Back-to-back: start held through DONE
    A = 4'd2; B = 4'd2; start = 1'b1;
    @(negedge clk);
    A = 4'd4; B = 4'd4;
    first_done = -1; second_done = -1;
    for (cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        start = 1'b0;
        check_eq("b2b_done_low", done, 0);
        check_eq("b2b_busy", busy, 1);
      end
      if (done && first_done < 0) begin
        first_done = cyc;
        check_eq("b2b_P1", P, 8'd4);
      end else if (done && second_done < 0) begin
        second_done = cyc;
        check_eq("b2b_P2", P, 8'd16);
      end
    end
    check_eq("b2b_first", first_done, 4);
    check_eq("b2b_spacing", second_done - first_done, 5);

    run_op("u7x9", 4'd7, 4'd9, 1'b0, 8'd63);

`ifdef SIGNED_MODE_EN
    run_op("s_m3x5", 4'hD, 4'd5, 1'b1, 8'hF1);
    run_op("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
    run_op("s_uDx5", 4'hD, 4'd5, 1'b0, 8'h41);
    run_op("s_7xm1", 4'd7, 4'hF, 1'b1, 8'hF9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
